// File: rtl/bcd_clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bcd_clock_pkg                                               |
// | Brief  : BCD digit type, time limits and BCD/12h helper functions.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package bcd_clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

    function automatic logic bcd_valid(bcd_t d);
        return (d <= 4'd9);
    endfunction

    function automatic logic bcd2_le(bcd_t ms, bcd_t ls, int max);
        int v;
        v = int'(ms) * 10 + int'(ls);
        return bcd_valid(ms) && bcd_valid(ls) && (v <= max);
    endfunction

    // Returns {ms, ls, pm}; midnight shows as 12 AM, noon as 12 PM.
    function automatic logic [8:0] to_12h(bcd_t ms, bcd_t ls);
        int   h;
        int   d;
        logic pm;
        h  = int'(ms) * 10 + int'(ls);
        pm = (h >= 12);
        if (h == 0)
            d = 12;
        else if (h > 12)
            d = h - 12;
        else
            d = h;
        return {4'(d / 10), 4'(d % 10), pm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_rtc_alarm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bcd_rtc_alarm_if                                            |
// | Brief  : Load/alarm control and time display bundle of the RTC.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface bcd_rtc_alarm_if;
    import bcd_clock_pkg::*;

    logic load;
    bcd_t load_hr_ms, load_hr_ls, load_min_ms, load_min_ls, load_sec_ms, load_sec_ls;
    logic mode_12h;
    logic alarm_set;
    logic alarm_clr;
    bcd_t alarm_hr_ms, alarm_hr_ls, alarm_min_ms, alarm_min_ls;
    bcd_t time_hr_ms, time_hr_ls, time_min_ms, time_min_ls, time_sec_ms, time_sec_ls;
    logic pm;
    logic tick_1hz;
    logic alarm_hit;
    logic load_err;

    modport master (
        output load, load_hr_ms, load_hr_ls, load_min_ms, load_min_ls, load_sec_ms, load_sec_ls,
        output mode_12h, alarm_set, alarm_clr,
        output alarm_hr_ms, alarm_hr_ls, alarm_min_ms, alarm_min_ls,
        input  time_hr_ms, time_hr_ls, time_min_ms, time_min_ls, time_sec_ms, time_sec_ls,
        input  pm, tick_1hz, alarm_hit, load_err
    );

    modport slave (
        input  load, load_hr_ms, load_hr_ls, load_min_ms, load_min_ls, load_sec_ms, load_sec_ls,
        input  mode_12h, alarm_set, alarm_clr,
        input  alarm_hr_ms, alarm_hr_ls, alarm_min_ms, alarm_min_ls,
        output time_hr_ms, time_hr_ls, time_min_ms, time_min_ls, time_sec_ms, time_sec_ls,
        output pm, tick_1hz, alarm_hit, load_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bcd_mod_counter                                             |
// | Brief  : Two-digit BCD counter 00..MAX with load, inc and carry.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bcd_mod_counter
    import bcd_clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  load,
    input  bcd_t load_ms,
    input  bcd_t load_ls,
    input  wire  inc,
    output bcd_t ms,
    output bcd_t ls,
    output bcd_t nxt_ms,
    output bcd_t nxt_ls,
    output logic carry_out
);
    localparam bcd_t MAX_MS = 4'(MAX / 10);
    localparam bcd_t MAX_LS = 4'(MAX % 10);

    bcd_t ms_q, ls_q, ms_d, ls_d;
    logic at_max;

    always_comb begin
        ms_d      = ms_q;
        ls_d      = ls_q;
        at_max    = (ms_q == MAX_MS) && (ls_q == MAX_LS);
        carry_out = inc && !load && at_max;
        if (load) begin
            ms_d = load_ms;
            ls_d = load_ls;
        end else if (inc) begin
            if (at_max) begin
                ms_d = 4'd0;
                ls_d = 4'd0;
            end else if (ls_q == 4'd9) begin
                ms_d = ms_q + 4'd1;
                ls_d = 4'd0;
            end else begin
                ls_d = ls_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_q <= 4'd0;
            ls_q <= 4'd0;
        end else begin
            ms_q <= ms_d;
            ls_q <= ls_d;
        end
    end

    assign ms     = ms_q;
    assign ls     = ls_q;
    assign nxt_ms = ms_d;
    assign nxt_ls = ls_d;
endmodule
`default_nettype wire

// File: rtl/bcd_rtc_alarm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bcd_rtc_alarm                                               |
// | Brief  : BCD HH:MM:SS clock with prescaler, 12/24h view and alarm.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bcd_rtc_alarm
    import bcd_clock_pkg::*;
#(
    parameter int CLK_HZ   = 1,
    parameter int ALARM_EN = 1
) (
    input wire clk,
    input wire rst,
    bcd_rtc_alarm_if.slave bus
);
    localparam int             PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] ps_q, ps_d;
    logic          load_err_q, load_err_d;
    logic          load_ok, load_bad, at_last, tick;
    logic          alarm_bad, alarm_hit;
    logic          sec_carry, min_carry, hr_carry;
    bcd_t          sec_ms, sec_ls, min_ms, min_ls, hr_ms, hr_ls;
    bcd_t          sec_nms, sec_nls, min_nms, min_nls, hr_nms, hr_nls;
    logic [8:0]    hr12;

    assign load_ok  = bus.load
                   && bcd2_le(bus.load_hr_ms,  bus.load_hr_ls,  HR_MAX)
                   && bcd2_le(bus.load_min_ms, bus.load_min_ls, MIN_MAX)
                   && bcd2_le(bus.load_sec_ms, bus.load_sec_ls, SEC_MAX);
    assign load_bad = bus.load && !load_ok;
    assign at_last  = (ps_q == PS_LAST);
    // A rejected load is ignored entirely, so only an accepted one masks the tick.
    assign tick     = at_last && !load_ok && !rst;

    always_comb begin
        ps_d       = ps_q + PW'(1);
        if (load_ok || at_last)
            ps_d = '0;
        load_err_d = load_bad || alarm_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q       <= '0;
            load_err_q <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            load_err_q <= load_err_d;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .load(load_ok),
        .load_ms(bus.load_sec_ms), .load_ls(bus.load_sec_ls),
        .inc(tick), .ms(sec_ms), .ls(sec_ls),
        .nxt_ms(sec_nms), .nxt_ls(sec_nls), .carry_out(sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .load(load_ok),
        .load_ms(bus.load_min_ms), .load_ls(bus.load_min_ls),
        .inc(sec_carry), .ms(min_ms), .ls(min_ls),
        .nxt_ms(min_nms), .nxt_ls(min_nls), .carry_out(min_carry)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .clk(clk), .rst(rst), .load(load_ok),
        .load_ms(bus.load_hr_ms), .load_ls(bus.load_hr_ls),
        .inc(min_carry), .ms(hr_ms), .ls(hr_ls),
        .nxt_ms(hr_nms), .nxt_ls(hr_nls), .carry_out(hr_carry)
    );

    generate
        if (ALARM_EN != 0) begin : g_alarm
            bcd_t al_hms_q, al_hls_q, al_mms_q, al_mls_q;
            bcd_t al_hms_d, al_hls_d, al_mms_d, al_mls_d;
            logic armed_q, armed_d, hit_q, hit_d, set_ok;

            always_comb begin
                set_ok   = bus.alarm_set
                        && bcd2_le(bus.alarm_hr_ms,  bus.alarm_hr_ls,  HR_MAX)
                        && bcd2_le(bus.alarm_min_ms, bus.alarm_min_ls, MIN_MAX);
                al_hms_d = al_hms_q;
                al_hls_d = al_hls_q;
                al_mms_d = al_mms_q;
                al_mls_d = al_mls_q;
                armed_d  = armed_q;
                if (bus.alarm_clr) begin
                    armed_d = 1'b0;
                end else if (set_ok) begin
                    al_hms_d = bus.alarm_hr_ms;
                    al_hls_d = bus.alarm_hr_ls;
                    al_mms_d = bus.alarm_min_ms;
                    al_mls_d = bus.alarm_min_ls;
                    armed_d  = 1'b1;
                end
                // Compare against the post-increment time so the pulse lines up with HH:MM:00.
                hit_d = tick && armed_q
                     && ({sec_nms, sec_nls} == 8'h00)
                     && ({min_nms, min_nls} == {al_mms_q, al_mls_q})
                     && ({hr_nms, hr_nls}   == {al_hms_q, al_hls_q});
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    al_hms_q <= 4'd0;
                    al_hls_q <= 4'd0;
                    al_mms_q <= 4'd0;
                    al_mls_q <= 4'd0;
                    armed_q  <= 1'b0;
                    hit_q    <= 1'b0;
                end else begin
                    al_hms_q <= al_hms_d;
                    al_hls_q <= al_hls_d;
                    al_mms_q <= al_mms_d;
                    al_mls_q <= al_mls_d;
                    armed_q  <= armed_d;
                    hit_q    <= hit_d;
                end
            end

            assign alarm_bad = bus.alarm_set && !set_ok;
            assign alarm_hit = hit_q;
        end else begin : g_no_alarm
            assign alarm_bad = 1'b0;
            assign alarm_hit = 1'b0;
        end
    endgenerate

    assign hr12            = to_12h(hr_ms, hr_ls);
    assign bus.time_hr_ms  = bus.mode_12h ? hr12[8:5] : hr_ms;
    assign bus.time_hr_ls  = bus.mode_12h ? hr12[4:1] : hr_ls;
    assign bus.time_min_ms = min_ms;
    assign bus.time_min_ls = min_ls;
    assign bus.time_sec_ms = sec_ms;
    assign bus.time_sec_ls = sec_ls;
    assign bus.pm          = hr12[0];
    assign bus.tick_1hz    = tick;
    assign bus.alarm_hit   = alarm_hit;
    assign bus.load_err    = load_err_q;
endmodule
`default_nettype wire
